// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 3;   // holds ALU_LAT-1 for ALU_LAT up to 7

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_RSVD  = 2'b11
  } alu_op_e;

  // Wait-counter preload: ALU_LAT-1, clamped so ALU_LAT=0 stays legal.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return (lat > 0) ? CNT_W'(lat - 1) : '0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. prio picks the winner only on contention;
// advance gates whether any grant is issued this cycle.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       gnt_id
);

  // Winner selection: lone requester wins, otherwise the prio side.
  always_comb begin
    gnt_id = 1'b0;
    if (req == 2'b11) gnt_id = prio;
    else if (req[1])  gnt_id = 1'b1;
    grant = 2'b00;
    if (advance && (req != 2'b00)) grant = gnt_id ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one EX-stage ALU between the pipeline slot (port 0) and the
// branch/address helper (port 1). One operation in flight at a time.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [3:0]        req0_func,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [3:0]        req1_func,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [1:0]        alu_op,
  output logic [3:0]        alu_func,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_issue,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              busy
);

  typedef struct packed {
    logic [1:0]        op;
    logic [3:0]        func;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  localparam logic [CNT_W-1:0] CNT_INIT = lat_load(ALU_LAT);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              id_q, id_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              zero_q, zero_d;

  logic [1:0] grant;
  logic       gnt_id;
  logic       arb_en;

  // Arbitration only while idle and not being flushed.
  assign arb_en = (state_q == IDLE) && !flush;

  rr_arb2 u_arb (
    .req     ({req1_valid, req0_valid}),
    .prio    (prio_q),
    .advance (arb_en),
    .grant   (grant),
    .gnt_id  (gnt_id)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Next-state: accept, issue, count down the ALU latency, hold the response.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d = ISSUE;
          id_d    = gnt_id;
          prio_d  = ~gnt_id;
          if (gnt_id) begin
            req_d.op = req1_op;  req_d.func = req1_func;
            req_d.a  = req1_a;   req_d.b    = req1_b;
          end else begin
            req_d.op = req0_op;  req_d.func = req0_func;
            req_d.a  = req0_a;   req_d.b    = req0_b;
          end
        end
      end
      ISSUE: begin
        if (ALU_LAT == 0) begin
          data_d  = alu_result;
          zero_d  = alu_zero;
          state_d = RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d  = alu_result;
          zero_d  = alu_zero;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush aborts whatever is in flight; a result captured this cycle is dropped.
    if (flush) begin
      state_d = IDLE;
      data_d  = data_q;
      zero_d  = zero_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      req_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign alu_op    = req_q.op;
  assign alu_func  = req_q.func;
  assign alu_a     = req_q.a;
  assign alu_b     = req_q.b;
  assign alu_issue = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_zero  = zero_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three instances at ALU_LAT 1, 4 and 0, each fed by a
// stand-in ALU that only presents the true result in the cycle it should be sampled.
module tb_alu_arbiter;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          flush [3], rv0 [3], rv1 [3], rdy0 [3], rdy1 [3], rsp_ready [3];
  logic          alu_issue [3], alu_zero [3], rsp_valid [3], rsp_id [3], rsp_zero [3], busy [3];
  logic [1:0]    op0 [3], op1 [3], alu_op [3];
  logic [3:0]    fn0 [3], fn1 [3], alu_func [3];
  logic [DW-1:0] a0 [3], b0 [3], a1 [3], b1 [3], alu_a [3], alu_b [3], alu_result [3], rsp_data [3];

  int errors = 0;
  int checks = 0;

  // Reference ALU behaviour (stand-in for ALUControl + ALU core).
  function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [3:0] fn,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: begin
        case (fn)
          4'b0010: return a + b;
          4'b0110: return a - b;
          4'b0000: return a & b;
          4'b0001: return a | b;
          4'b0111: return DW'($signed(a) < $signed(b));
          default: return '0;
        endcase
      end
      default: return a ^ b;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : (g == 1) ? 4 : 0;
    int age = 100;
    logic good;
    logic [DW-1:0] res;
    // Cycles since the last issue strobe; result is only true at age == L.
    always @(posedge clk) age <= alu_issue[g] ? 1 : ((age < 100) ? age + 1 : age);
    assign res  = ref_alu(alu_op[g], alu_func[g], alu_a[g], alu_b[g]);
    assign good = alu_issue[g] ? (L == 0) : (age == L);
    assign alu_result[g] = good ? res : ~res;
    assign alu_zero[g]   = good ? (res == '0) : (res != '0);

    alu_arbiter #(.DATA_W(DW), .ALU_LAT(L)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush[g]),
      .req0_valid(rv0[g]), .req0_ready(rdy0[g]), .req0_op(op0[g]), .req0_func(fn0[g]),
      .req0_a(a0[g]), .req0_b(b0[g]),
      .req1_valid(rv1[g]), .req1_ready(rdy1[g]), .req1_op(op1[g]), .req1_func(fn1[g]),
      .req1_a(a1[g]), .req1_b(b1[g]),
      .alu_op(alu_op[g]), .alu_func(alu_func[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]),
      .alu_issue(alu_issue[g]), .alu_result(alu_result[g]), .alu_zero(alu_zero[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_id(rsp_id[g]),
      .rsp_data(rsp_data[g]), .rsp_zero(rsp_zero[g]), .busy(busy[g])
    );
  end

  function automatic logic [60:0] outs(input int k);
    return {alu_op[k], alu_func[k], alu_a[k], alu_b[k], alu_issue[k], rsp_valid[k], rsp_id[k],
            rsp_data[k], rsp_zero[k], busy[k], rdy0[k], rdy1[k]};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_ops(input int k);
    op0[k] = 2'($urandom_range(0, 3)); fn0[k] = 4'($urandom); a0[k] = 16'($urandom); b0[k] = 16'($urandom);
    op1[k] = 2'($urandom_range(0, 3)); fn1[k] = 4'($urandom); a1[k] = 16'($urandom); b1[k] = 16'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (outs(k) !== '0) begin errors++; $display("FAIL reset_hold[%0d] got=%h want=0", k, outs(k)); end
    end
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (outs(k) !== '0) begin errors++; $display("FAIL reset_release[%0d] got=%h want=0", k, outs(k)); end
    end
  endtask

  task automatic test_contention();
    int gnt[$], rsp[$], gcyc[$];
    logic [DW-1:0] expd[$];
    logic [DW-1:0] d;
    int cyc = 0;
    int eid;
    rsp_ready[0] = 1'b1;
    while (rsp.size() < 4 && cyc < 60) begin
      rv0[0] = (gnt.size() < 4);
      rv1[0] = (gnt.size() < 4);
      rand_ops(0);
      #1;
      checks++;
      if (rdy0[0] && rdy1[0]) begin errors++; $display("FAIL cont_both_ready cyc=%0d got=11 want=one-hot", cyc); end
      if (rdy0[0] || rdy1[0]) begin
        eid = gnt.size() % 2;
        gnt.push_back(int'(rdy1[0]));
        gcyc.push_back(cyc);
        expd.push_back(eid ? ref_alu(op1[0], fn1[0], a1[0], b1[0]) : ref_alu(op0[0], fn0[0], a0[0], b0[0]));
      end
      if (rsp_valid[0]) begin
        rsp.push_back(int'(rsp_id[0]));
        checks++;
        if (expd.size() == 0) begin
          errors++; $display("FAIL cont_rsp_unexpected got=%h want=none", rsp_data[0]);
        end else begin
          d = expd.pop_front();
          if (rsp_data[0] !== d) begin errors++; $display("FAIL cont_rsp_data got=%h want=%h", rsp_data[0], d); end
        end
      end
      step();
      cyc++;
    end
    rv0[0] = 1'b0; rv1[0] = 1'b0;
    checks++;
    if (rsp.size() != 4) begin errors++; $display("FAIL cont_rsp_count got=%0d want=4", rsp.size()); end
    for (int i = 0; i < gnt.size(); i++) begin
      checks++;
      if (gnt[i] != i % 2) begin errors++; $display("FAIL cont_grant[%0d] got=%0d want=%0d", i, gnt[i], i % 2); end
    end
    for (int i = 1; i < gcyc.size(); i++) begin
      checks++;
      if (gcyc[i] - gcyc[i-1] != 4) begin errors++; $display("FAIL cont_spacing[%0d] got=%0d want=4", i, gcyc[i] - gcyc[i-1]); end
    end
    for (int i = 0; i < rsp.size(); i++) begin
      checks++;
      if (rsp[i] != i % 2) begin errors++; $display("FAIL cont_rsp_id[%0d] got=%0d want=%0d", i, rsp[i], i % 2); end
    end
    step();
  endtask

  task automatic test_single();
    rsp_ready[0] = 1'b1;
    rv0[0] = 1'b1; op0[0] = 2'b10; fn0[0] = 4'b0010; a0[0] = 16'd5; b0[0] = 16'd3;
    #1;
    checks++;
    if ({rdy0[0], rdy1[0]} !== 2'b10) begin errors++; $display("FAIL single_ready got=%b want=10", {rdy0[0], rdy1[0]}); end
    step();
    rv0[0] = 1'b0;
    #1;
    checks++;
    if ({alu_issue[0], alu_op[0], alu_func[0], alu_a[0], alu_b[0], busy[0]} !== {1'b1, 2'b10, 4'b0010, 16'd5, 16'd3, 1'b1})
      begin errors++; $display("FAIL single_issue got=%b/%h/%h want=1/5/3", alu_issue[0], alu_a[0], alu_b[0]); end
    step();
    checks++;
    if ({alu_issue[0], rsp_valid[0], busy[0]} !== 3'b001) begin errors++; $display("FAIL single_wait got=%b want=001", {alu_issue[0], rsp_valid[0], busy[0]}); end
    step();
    checks++;
    if ({rsp_valid[0], rsp_id[0], rsp_data[0], rsp_zero[0]} !== {1'b1, 1'b0, 16'd8, 1'b0})
      begin errors++; $display("FAIL single_rsp got=%b/%b/%h want=1/0/0008", rsp_valid[0], rsp_id[0], rsp_data[0]); end
    step();
    checks++;
    if ({rsp_valid[0], busy[0]} !== 2'b00) begin errors++; $display("FAIL single_idle got=%b want=00", {rsp_valid[0], busy[0]}); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] ed;
    int w = 0;
    rsp_ready[0] = 1'b0;
    rand_ops(0);
    rv1[0] = 1'b1; op1[0] = 2'b00;
    ed = a1[0] + b1[0];
    #1;
    checks++;
    if ({rdy0[0], rdy1[0]} !== 2'b01) begin errors++; $display("FAIL bp_accept got=%b want=01", {rdy0[0], rdy1[0]}); end
    step();
    rv1[0] = 1'b0;
    while (!rsp_valid[0] && w < 20) begin step(); w++; end
    checks++;
    if (w != 2) begin errors++; $display("FAIL bp_latency got=%0d want=2", w); end
    rv0[0] = 1'b1; rv1[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({rsp_valid[0], rsp_id[0], rsp_data[0], rsp_zero[0], busy[0], rdy0[0], rdy1[0]} !== {1'b1, 1'b1, ed, ed == '0, 1'b1, 2'b00})
        begin errors++; $display("FAIL bp_hold[%0d] got=%b/%b/%h/%b/%b want=1/1/%h/1/00", i, rsp_valid[0], rsp_id[0],
                                 rsp_data[0], busy[0], {rdy0[0], rdy1[0]}, ed); end
      step();
    end
    rsp_ready[0] = 1'b1; rv0[0] = 1'b0; rv1[0] = 1'b0;
    step();
    checks++;
    if ({rsp_valid[0], busy[0]} !== 2'b00) begin errors++; $display("FAIL bp_release got=%b want=00", {rsp_valid[0], busy[0]}); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] ed;
    rsp_ready[1] = 1'b1;
    rand_ops(1);
    rv0[1] = 1'b1;
    #1;
    checks++;
    if (rdy0[1] !== 1'b1) begin errors++; $display("FAIL flush_accept got=%b want=1", rdy0[1]); end
    step();
    rv0[1] = 1'b0;
    step();
    step();
    flush[1] = 1'b1; rv0[1] = 1'b1; rv1[1] = 1'b1;
    #1;
    checks++;
    if ({rdy0[1], rdy1[1], busy[1]} !== 3'b001) begin errors++; $display("FAIL flush_block got=%b want=001", {rdy0[1], rdy1[1], busy[1]}); end
    step();
    flush[1] = 1'b0;
    #1;
    checks++;
    if ({busy[1], rsp_valid[1], rdy0[1], rdy1[1]} !== 4'b0001)
      begin errors++; $display("FAIL flush_idle_prio got=%b want=0001", {busy[1], rsp_valid[1], rdy0[1], rdy1[1]}); end
    ed = ref_alu(op1[1], fn1[1], a1[1], b1[1]);
    step();
    rv0[1] = 1'b0; rv1[1] = 1'b0;
    #1;
    checks++;
    if ({alu_issue[1], alu_a[1], alu_b[1]} !== {1'b1, a1[1], b1[1]})
      begin errors++; $display("FAIL flush_next_issue got=%b/%h/%h want=1/%h/%h", alu_issue[1], alu_a[1], alu_b[1], a1[1], b1[1]); end
    for (int i = 2; i <= 6; i++) begin
      step();
      checks++;
      if (rsp_valid[1] !== (i == 6)) begin errors++; $display("FAIL flush_rsp_time[%0d] got=%b want=%b", i, rsp_valid[1], i == 6); end
    end
    checks++;
    if ({rsp_id[1], rsp_data[1], rsp_zero[1]} !== {1'b1, ed, ed == '0})
      begin errors++; $display("FAIL flush_rsp got=%b/%h want=1/%h", rsp_id[1], rsp_data[1], ed); end
    step();
  endtask

  task automatic test_lat0();
    rsp_ready[2] = 1'b1;
    rv1[2] = 1'b1; op1[2] = 2'b01; fn1[2] = 4'($urandom); a1[2] = 16'd7; b1[2] = 16'd7;
    #1;
    checks++;
    if (rdy1[2] !== 1'b1) begin errors++; $display("FAIL lat0_accept got=%b want=1", rdy1[2]); end
    step();
    rv1[2] = 1'b0;
    checks++;
    if ({alu_issue[2], rsp_valid[2]} !== 2'b10) begin errors++; $display("FAIL lat0_issue got=%b want=10", {alu_issue[2], rsp_valid[2]}); end
    step();
    checks++;
    if ({rsp_valid[2], rsp_zero[2], rsp_id[2], rsp_data[2]} !== {3'b111, 16'd0})
      begin errors++; $display("FAIL lat0_rsp got=%b/%b/%b/%h want=1/1/1/0000", rsp_valid[2], rsp_zero[2], rsp_id[2], rsp_data[2]); end
    step();
    checks++;
    if (busy[2] !== 1'b0) begin errors++; $display("FAIL lat0_idle got=%b want=0", busy[2]); end
    // flush wins over a simultaneous response handshake
    rand_ops(2);
    rv0[2] = 1'b1;
    step();
    rv0[2] = 1'b0;
    step();
    flush[2] = 1'b1;
    #1;
    checks++;
    if (rsp_valid[2] !== 1'b1) begin errors++; $display("FAIL lat0_flush_pre got=%b want=1", rsp_valid[2]); end
    step();
    flush[2] = 1'b0; rv0[2] = 1'b1; rv1[2] = 1'b1;
    #1;
    checks++;
    if ({rsp_valid[2], busy[2], rdy0[2], rdy1[2]} !== 4'b0001)
      begin errors++; $display("FAIL lat0_flush_post got=%b want=0001", {rsp_valid[2], busy[2], rdy0[2], rdy1[2]}); end
    step();
    rv0[2] = 1'b0; rv1[2] = 1'b0;
    step();
    checks++;
    if ({rsp_valid[2], rsp_id[2], rsp_data[2]} !== {2'b11, ref_alu(op1[2], fn1[2], a1[2], b1[2])})
      begin errors++; $display("FAIL lat0_after_flush got=%b/%b/%h", rsp_valid[2], rsp_id[2], rsp_data[2]); end
    step();
  endtask

  task automatic test_reset_mid();
    rsp_ready[1] = 1'b1;
    rand_ops(1);
    rv0[1] = 1'b1;
    step();
    rv0[1] = 1'b0;
    step();
    checks++;
    if (busy[1] !== 1'b1) begin errors++; $display("FAIL rstmid_busy got=%b want=1", busy[1]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs(1) !== '0) begin errors++; $display("FAIL rstmid_async got=%h want=0", outs(1)); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({rsp_valid[1], busy[1]} !== 2'b00) begin errors++; $display("FAIL rstmid_after[%0d] got=%b want=00", i, {rsp_valid[1], busy[1]}); end
    end
  endtask

  // Cycle-timed model: an accepted op issues one cycle later and responds from
  // cycle accept+2+L until delivered; flush drops it.
  task automatic test_random();
    localparam int L = 1;
    logic out = 1'b0, p = 1'b0, eid = 1'b0, gid;
    logic e_r0, e_r1, e_busy, e_iss, e_rv;
    logic [37:0] eops;
    logic [DW-1:0] ed;
    int acc = 0, age, done = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rand_ops(0);
      rv0[0] = 1'($urandom_range(0, 1));
      rv1[0] = 1'($urandom_range(0, 1));
      rsp_ready[0] = ($urandom_range(0, 3) != 0);
      flush[0] = ($urandom_range(0, 19) == 0);
      #1;
      e_r0 = 1'b0; e_r1 = 1'b0; e_busy = out; e_iss = 1'b0; e_rv = 1'b0;
      if (!out) begin
        if (!flush[0] && (rv0[0] || rv1[0])) begin
          gid = (rv0[0] && rv1[0]) ? p : rv1[0];
          e_r0 = !gid; e_r1 = gid;
        end
      end else begin
        age = c - acc;
        e_iss = (age == 1);
        e_rv = (age >= 2 + L);
      end
      checks++;
      if ({rdy0[0], rdy1[0], busy[0], alu_issue[0], rsp_valid[0]} !== {e_r0, e_r1, e_busy, e_iss, e_rv})
        begin errors++; $display("FAIL rand_ctl cyc=%0d got=%b want=%b", c,
                                 {rdy0[0], rdy1[0], busy[0], alu_issue[0], rsp_valid[0]}, {e_r0, e_r1, e_busy, e_iss, e_rv}); end
      if (e_iss) begin
        checks++;
        if ({alu_op[0], alu_func[0], alu_a[0], alu_b[0]} !== eops)
          begin errors++; $display("FAIL rand_issue cyc=%0d got=%h want=%h", c, {alu_op[0], alu_func[0], alu_a[0], alu_b[0]}, eops); end
      end
      if (e_rv) begin
        checks++;
        if ({rsp_id[0], rsp_data[0], rsp_zero[0]} !== {eid, ed, ed == '0})
          begin errors++; $display("FAIL rand_rsp cyc=%0d got=%b/%h want=%b/%h", c, rsp_id[0], rsp_data[0], eid, ed); end
      end
      if (flush[0]) out = 1'b0;
      else if (!out && (e_r0 || e_r1)) begin
        out = 1'b1; acc = c; eid = e_r1; p = ~e_r1;
        eops = e_r1 ? {op1[0], fn1[0], a1[0], b1[0]} : {op0[0], fn0[0], a0[0], b0[0]};
        ed = ref_alu(eops[37:36], eops[35:32], eops[31:16], eops[15:0]);
      end else if (out && e_rv && rsp_ready[0]) begin
        out = 1'b0; done++;
      end
      step();
    end
    flush[0] = 1'b0; rv0[0] = 1'b0; rv1[0] = 1'b0;
    checks++;
    if (done < 20) begin errors++; $display("FAIL rand_progress got=%0d want>=20", done); end
  endtask

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      flush[k] = 1'b0; rv0[k] = 1'b0; rv1[k] = 1'b0; rsp_ready[k] = 1'b0;
      op0[k] = '0; fn0[k] = '0; a0[k] = '0; b0[k] = '0;
      op1[k] = '0; fn1[k] = '0; a1[k] = '0; b1[k] = '0;
    end
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_flush();
    test_lat0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
